// File: rtl/gps_gate_sequencer_pkg.sv
// Shared definitions for the GPS-disciplined gate sequencer: state encoding
// (also used by the SPI status register map) and default sizing.
package gps_gate_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_GATE = 2'd2
  } gate_state_t;

  localparam int DEFAULT_COUNT_WIDTH = 35;

  // Pulse loss is declared after 1.2 s of reference clock without an edge.
  localparam int REF_CLK_HZ             = 5_000_000;
  localparam int DEFAULT_TIMEOUT_CYCLES = REF_CLK_HZ * 6 / 5;
  localparam int DEFAULT_TIMEOUT_WIDTH  = $clog2(DEFAULT_TIMEOUT_CYCLES);

endpackage

// File: rtl/gps_gate_sequencer_pulse_edge_sync.sv
// Two-flop synchroniser for an asynchronous input plus a one-cycle strobe on
// each synchronised rising edge; falling edges are ignored.
module pulse_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic strobe
);

  logic sync_p0;
  logic sync_p1;
  logic sync_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      sync_p2 <= 1'b0;
    end else begin
      sync_p0 <= din;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  assign strobe = sync_p1 & ~sync_p2;

endmodule

// File: rtl/gps_gate_sequencer.sv
// Gate sequencer for the reference-clock frequency counter: opens and closes
// counting gates on synchronised GPS pulse events and latches each result.
module gps_gate_sequencer
  import gps_gate_sequencer_pkg::*;
#(
  parameter int COUNT_WIDTH    = DEFAULT_COUNT_WIDTH,
  parameter int GATE_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int TIMEOUT_WIDTH  = 23
) (
  input  logic                   system_clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   pps_in,
  input  logic [GATE_WIDTH-1:0]  gate_len,
  output logic [COUNT_WIDTH-1:0] result,
  output logic                   result_valid,
  input  logic                   result_ack,
  output logic                   result_saturated,
  output logic                   overrun,
  output logic                   pps_lost,
  input  logic                   clear_flags,
  output logic [1:0]             gate_state
);

  localparam logic [COUNT_WIDTH-1:0]   CNT_MAX  = '1;
  localparam logic [COUNT_WIDTH-1:0]   CNT_NEAR = CNT_MAX - 1'b1;
  localparam logic [TIMEOUT_WIDTH-1:0] TMO_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  gate_state_t              state;
  gate_state_t              state_next;
  logic                     evt;
  logic [COUNT_WIDTH-1:0]   cnt;
  logic                     sat_flag;
  logic [GATE_WIDTH-1:0]    ivl;
  logic [GATE_WIDTH-1:0]    len_q;
  logic [TIMEOUT_WIDTH-1:0] tmo;
  logic                     in_gate;
  logic                     open_gate;
  logic                     final_evt;
  logic                     timeout_hit;
  logic                     run;
  logic                     set_overrun;

  pulse_edge_sync u_pps_sync (
    .clk    (system_clk),
    .rst_n  (rst_n),
    .din    (pps_in),
    .strobe (evt)
  );

  // A final event closes one gate and opens the next in the same cycle.
  assign in_gate     = (state == ST_GATE);
  assign open_gate   = enable && evt && ((state == ST_SYNC) || (in_gate && (ivl == len_q)));
  assign final_evt   = open_gate && in_gate;
  assign timeout_hit = enable && in_gate && !evt && (tmo == TMO_LAST);
  assign run         = enable && in_gate && !timeout_hit;
  assign set_overrun = final_evt && result_valid && !result_ack;
  assign gate_state  = state;

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (!enable) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: state_next = ST_SYNC;
        ST_SYNC: if (evt) state_next = ST_GATE;
        ST_GATE: if (timeout_hit) state_next = ST_SYNC;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Counting stage: cycle counter, interval counter and timeout counter.
  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      sat_flag <= 1'b0;
      ivl      <= '0;
      len_q    <= '0;
      tmo      <= '0;
    end else if (open_gate) begin
      cnt      <= '0;
      sat_flag <= 1'b0;
      ivl      <= '0;
      len_q    <= gate_len;
      tmo      <= '0;
    end else if (run) begin
      cnt <= sat_inc(cnt);
      if (cnt == CNT_NEAR) sat_flag <= 1'b1;
      tmo <= evt ? '0 : tmo + 1'b1;
      if (evt) ivl <= ivl + 1'b1;
    end else begin
      cnt      <= '0;
      sat_flag <= 1'b0;
      ivl      <= '0;
      tmo      <= '0;
    end
  end

  // Result stage: latch on final event; a coincident ack loses to the new result.
  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      result           <= '0;
      result_valid     <= 1'b0;
      result_saturated <= 1'b0;
      overrun          <= 1'b0;
      pps_lost         <= 1'b0;
    end else begin
      if (final_evt) begin
        result           <= sat_inc(cnt);
        result_saturated <= sat_flag;
        result_valid     <= 1'b1;
      end else if (result_ack) begin
        result_valid <= 1'b0;
      end
      overrun  <= set_overrun | (overrun & ~clear_flags);
      pps_lost <= timeout_hit | (pps_lost & ~clear_flags);
    end
  end

endmodule

// File: doc/gps_gate_sequencer.md
Name: gps_gate_sequencer

Overview:
- Controls the GPS-disciplined reference-clock frequency counter.
- Synchronises the GPS pulse and opens and closes counting gates spanning a configurable number of pulse intervals.
- Latches each gate result and detects missing pulses, counter saturation and unread-result overrun.
- Sits between the raw GPS_PULSE pin and the SPI readout register. Replaces the ad-hoc gating logic in the top level.

Parameters:
COUNT_WIDTH, 35, width of the cycle counter and result.
GATE_WIDTH, 4, width of gate_len (gate spans gate_len+1 pulse intervals).
TIMEOUT_CYCLES, 6000000, cycles without a pulse edge before pulse loss is declared (must be ≥2).
TIMEOUT_WIDTH, 23, width of the timeout counter (must hold TIMEOUT_CYCLES).

Ports:
system_clk  in  1  single clock, all logic on rising edge.
rst_n  in  1  asynchronous active-low reset.
enable  in  1  run measurement; low forces IDLE.
pps_in  in  1  raw GPS pulse, asynchronous.
gate_len  in  GATE_WIDTH  pulse intervals per gate minus one; sampled at gate open.
result  out  COUNT_WIDTH  cycles counted over the last completed gate.
result_valid  out  1  result holds an unread value.
result_ack  in  1  one-cycle pulse from the readout side; consumes result.
result_saturated  out  1  counter saturated during the gate that produced result.
overrun  out  1  sticky: a new result arrived while result_valid was still high.
pps_lost  out  1  sticky: timeout expired while gating.
clear_flags  in  1  one-cycle pulse; clears overrun and pps_lost.
gate_state  out  2  0=IDLE, 1=SYNC, 2=GATE.

Behaviour:
- Reset: state IDLE, result=0, result_valid=0, result_saturated=0, overrun=0, pps_lost=0, all counters 0, synchroniser flops 0.
- Pulse path: 2-flop synchroniser, then a third flop for edge detect. The pulse event is a one-cycle strobe, 3 cycles after pps_in rises. Falling edges are ignored.
- IDLE:
  - counter and interval counter held at 0.
  - enable=1 moves to SYNC on the next cycle.
- SYNC:
  - Waits for the first pulse event.
  - On the event: counter=0, interval counter=0, gate_len latched, go to GATE.
  - The timeout counter is not armed in SYNC.
- GATE:
  - counter increments every cycle and saturates at all-ones. The saturation flag for the current gate sets when saturation is reached.
  - timeout counter increments every cycle and clears on each pulse event.
  - Non-final event (interval counter < latched gate_len): interval counter increments.
  - Final event (interval counter == latched gate_len):
    - result = counter+1, saturating, so result is the exact cycle distance between the opening and closing event strobes.
    - result_saturated = gate saturation flag.
    - result_valid=1.
    - The same cycle opens the next gate with no dead time: counter=0, interval counter=0, gate_len re-latched, saturation flag cleared.
  - Timeout reaching TIMEOUT_CYCLES-1 without an event: pps_lost=1, discard the partial gate, go to SYNC. result and result_valid are untouched.
- Overrun: if a final event occurs while result_valid=1 and result_ack is not asserted that cycle, set overrun=1. result is still overwritten with the newest value.
- Handshake:
  - result_ack clears result_valid the next cycle.
  - If result_ack coincides with a final event, the new result wins: result_valid stays 1 and no overrun is flagged.
- clear_flags coinciding with a flag-setting event: the set wins.
- enable=0 in any state: go to IDLE next cycle and discard the partial gate. Result, valid and flags are held.
- Changing gate_len mid-gate has no effect until the next gate opens.
- Asynchronous reset mid-gate returns everything to reset values immediately. The first gate after reset requires a fresh SYNC event.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE/SYNC/GATE) for use by the SPI status register mapping;
  - default COUNT_WIDTH;
  - TIMEOUT_CYCLES derived from the reference clock frequency.
- One sub-module, pulse_edge_sync: the synchroniser plus rising-edge strobe, reusable for the buttons and TEMP_ALERT.

Test Plan:
- gate_len=0, enable=1, pps rising every 100 cycles → gate_state goes SYNC then GATE; each result=100 with result_valid set. Ack every result → overrun stays 0.
- gate_len=2, pulses every 100 cycles → result=300, one result per three pulses. Change gate_len to 0 mid-gate → current result still 300, the following result is 100.
- TIMEOUT_CYCLES=500, pulses every 100 cycles then stop → pps_lost=1 exactly 500 cycles after the last event strobe; gate_state returns to SYNC; previous result retained. Pulses resume → first new result 100 after one interval.
- No ack on two consecutive results → overrun=1 and result equals the second value. Ack coinciding with a final event → valid stays 1 and overrun stays 0.
- COUNT_WIDTH=8, pulses every 300 cycles → result=255 and result_saturated=1. Next gate at 200-cycle spacing → result=200 and result_saturated=0.
- rst_n low for 1 cycle mid-gate, and separately enable low for 1 cycle → all outputs reset (rst_n) or held (enable); both cases restart via SYNC with no spurious result.
